// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle WIDTH-bit adder built around an external
// 4-bit ripple slice (add4). Operands are latched on start, one nibble per
// clock is presented to the slice, and the slice carry is chained forward.
// The full sum and final carry are published with a one-cycle done pulse.
// Optional feature: define NSA_OVERFLOW_EN to add a registered signed
// overflow flag (ovf) that updates together with sum.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_s,
    input  logic             add_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef NSA_OVERFLOW_EN
    output logic             c_out,
    output logic             ovf
`else
    output logic             c_out
`endif
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    // Width must split into whole nibbles; anything else is a build error.
    generate
        if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] work_r;
    logic             carry_r;
    logic [IDX_W-1:0] idx;

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [WIDTH-1:0] next_work;
    logic             last_nib;

    assign last_nib = (idx == IDX_W'(NIBBLES - 1));

    // Select the current nibble of each latched operand.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
                nib_a = a_r[4*i +: 4];
                nib_b = b_r[4*i +: 4];
            end
        end
    end

    // Work word with this cycle's slice result merged in; the last nibble's
    // merge is what gets published as the final sum.
    always_comb begin
        next_work = work_r;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
                next_work[4*i +: 4] = add_s;
            end
        end
    end

    // Slice operands are only driven while running so the slice sits at 0
    // otherwise.
    assign add_a   = (state == S_RUN) ? nib_a   : 4'd0;
    assign add_b   = (state == S_RUN) ? nib_b   : 4'd0;
    assign add_cin = (state == S_RUN) ? carry_r : 1'b0;

`ifdef NSA_OVERFLOW_EN
    logic ovf_new;
    // Two's-complement overflow: same-sign operands giving a different-sign sum.
    assign ovf_new = (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                     (next_work[WIDTH-1] != a_r[WIDTH-1]);
`endif

    // Sequencer FSM with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            work_r  <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            c_out   <= 1'b0;
`ifdef NSA_OVERFLOW_EN
            ovf     <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= c_in;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= S_RUN;
                    end else begin
                        state   <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // start is deliberately not looked at here.
                    work_r  <= next_work;
                    carry_r <= add_cout;
                    idx     <= idx + 1'b1;
                    if (last_nib) begin
                        sum   <= next_work;
                        c_out <= add_cout;
`ifdef NSA_OVERFLOW_EN
                        ovf   <= ovf_new;
`endif
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (WIDTH=16) with a behavioural add4 slice.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_s;
    logic        add_cout;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        c_out;
`ifdef NSA_OVERFLOW_EN
    logic        ovf;
`endif

    always #5 clk = ~clk;

    // Behavioural 4-bit ripple slice.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
`ifdef NSA_OVERFLOW_EN
        .c_out    (c_out),
        .ovf      (ovf)
`else
        .c_out    (c_out)
`endif
    );

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;

    logic [3:0]  hist_a[$];
    logic        hist_cin[$];
    logic [15:0] hist_sum[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                mon_e = sb.pop_front();
                chk("sum", 32'(sum), 32'(mon_e.s));
                chk("c_out", 32'(c_out), 32'(mon_e.co));
                chk("done_busy_excl", 32'(busy), 32'd0);
`ifdef NSA_OVERFLOW_EN
                chk("ovf", 32'(ovf), 32'(mon_e.ov));
`endif
            end
        end
    end

    // Drive a start request (caller is at a negedge); optionally log the
    // expected result. Returns just after the accepting edge.
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                         input bit push, input logic [15:0] es, input logic eco,
                         input logic eov);
        exp_t e;
        a = ta; b = tb_v; c_in = tc; start = 1'b1;
        if (push) begin
            e.s = es; e.co = eco; e.ov = eov;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count edges from the start sample until done is seen, logging slice
    // traffic on each running cycle. Returns at the negedge of the done cycle.
    task automatic wait_done(input int first, output int edges);
        bit seen = 0;
        hist_a.delete(); hist_cin.delete(); hist_sum.delete();
        edges = first;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
            end else begin
                if (busy) begin
                    hist_a.push_back(add_a);
                    hist_cin.push_back(add_cin);
                    hist_sum.push_back(sum);
                end
                @(posedge clk);
                edges++;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within 20 cycles");
        end
    endtask

    function automatic logic [15:0] pack_a();
        logic [15:0] v = '0;
        foreach (hist_a[i]) v = {v[11:0], hist_a[i]};
        return v;
    endfunction

    function automatic logic [3:0] pack_cin();
        logic [3:0] v = '0;
        foreach (hist_cin[i]) v = {v[2:0], hist_cin[i]};
        return v;
    endfunction

    initial begin
        int lat;
        int bad;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(c_out), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        rst_n = 1'b1;

        // Basic add with latency and nibble order.
        @(negedge clk);
        issue(16'h1234, 16'h4321, 1'b0, 1, 16'h5555, 1'b0, 1'b0);
        wait_done(1, lat);
        chk("basic_latency", 32'(lat), 32'd5);
        chk("basic_add_a_seq", 32'(pack_a()), 32'h4321);

        // Carry ripples through every nibble.
        @(negedge clk);
        issue(16'hFFFF, 16'h0001, 1'b0, 1, 16'h0000, 1'b1, 1'b0);
        wait_done(1, lat);
        chk("ripple_cin_seq", 32'(pack_cin()), 32'h7);
        chk("ripple_latency", 32'(lat), 32'd5);

        // Carry-in only.
        @(negedge clk);
        issue(16'hFFFF, 16'h0000, 1'b1, 1, 16'h0000, 1'b1, 1'b0);
        wait_done(1, lat);
        @(negedge clk);
        issue(16'h0000, 16'h0000, 1'b1, 1, 16'h0001, 1'b0, 1'b0);
        wait_done(1, lat);
        chk("cin_only_cin_seq", 32'(pack_cin()), 32'h8);

        // start during RUN is ignored.
        @(negedge clk);
        issue(16'h0005, 16'h0006, 1'b0, 1, 16'h000B, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'hAAAA; b = 16'hAAAA; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(2, lat);
        chk("ignored_latency", 32'(lat), 32'd5);
        // Back-to-back start in the DONE cycle.
        issue(16'h000C, 16'h000D, 1'b0, 1, 16'h0019, 1'b0, 1'b0);
        wait_done(1, lat);
        chk("b2b_latency", 32'(lat), 32'd5);
        bad = 0;
        foreach (hist_sum[i]) if (hist_sum[i] !== 16'h000B) bad++;
        chk("sum_hold_len", 32'(hist_sum.size()), 32'd4);
        chk("sum_hold", 32'(bad), 32'd0);

        // Reset mid-RUN discards the operation.
        @(negedge clk);
        issue(16'h1234, 16'h4321, 1'b0, 0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(c_out), 32'd0);
        chk("midrst_add_a", 32'(add_a), 32'd0);
        rst_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("midrst_no_done", 32'(bad), 32'd0);

`ifdef NSA_OVERFLOW_EN
        @(negedge clk);
        issue(16'h7FFF, 16'h0001, 1'b0, 1, 16'h8000, 1'b0, 1'b1);
        wait_done(1, lat);
        @(negedge clk);
        issue(16'h8000, 16'h8000, 1'b0, 1, 16'h0000, 1'b1, 1'b1);
        wait_done(1, lat);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
